// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, ID-branch flushes and a data-memory freeze FSM with timeout.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_memread_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_flush_o,
  output logic             exmem_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_e     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       freeze;
  logic       loaduse;
  logic       bubble;
  logic       flush;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_d = MEMWAIT;
          tcnt_d  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (dmem_ack_i) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TIMEOUT) begin
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    freeze = 1'b0;
    case (state_q)
      IDLE:    freeze = dmem_req_i && !dmem_ack_i;
      MEMWAIT: freeze = !dmem_ack_i;
      ERR:     freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  assign loaduse = ex_memread_i && (ex_rt_i != 5'd0) &&
                   ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // Reset gates every control so a held reset never stalls or flushes.
  always_comb begin
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_stall_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_stall_o = 1'b0;
    if (rst_i) begin
      if (freeze) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_stall_o  = 1'b1;
        exmem_stall_o = 1'b1;
      end else if (loaduse) begin
        pc_stall_o   = 1'b1;
        ifid_stall_o = 1'b1;
        idex_flush_o = 1'b1;
      end else if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  assign err_o  = (state_q == ERR);
  assign bubble = idex_flush_o;
  assign flush  = ifid_flush_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, mw_cnt_q, fl_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if (bubble && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 1'b1;
      if (freeze && (mw_cnt_q != '1)) mw_cnt_q <= mw_cnt_q + 1'b1;
      if (flush  && (fl_cnt_q != '1)) fl_cnt_q <= fl_cnt_q + 1'b1;
    end
  end

  assign loaduse_cnt_o = lu_cnt_q;
  assign memwait_cnt_o = mw_cnt_q;
  assign flush_cnt_o   = fl_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = bubble ^ flush;
  assign loaduse_cnt_o = '0;
  assign memwait_cnt_o = '0;
  assign flush_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural reference model.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memread = 1'b0, branch = 1'b0, req = 1'b0, ack = 1'b0;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, err;
  logic [CNT_W-1:0] lu_cnt, mw_cnt, fl_cnt;

  int checks = 0;
  int failures = 0;

  // reference model: an access is "pending" once it has gone unacked; it errors after
  // more than MEM_TIMEOUT+... consecutive unacked frozen cycles beyond the request cycle
  int m_unacked = 0;
  bit m_err = 1'b0;
  longint m_lu = 0, m_mw = 0, m_fl = 0;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_rt_i(ex_rt), .ex_memread_i(ex_memread), .branch_taken_i(branch),
    .dmem_req_i(req), .dmem_ack_i(ack),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_stall_o(idex_stall), .idex_flush_o(idex_flush), .exmem_stall_o(exmem_stall),
    .err_o(err), .loaduse_cnt_o(lu_cnt), .memwait_cnt_o(mw_cnt), .flush_cnt_o(fl_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_frozen();
    if (m_err) return 1'b1;
    if (m_unacked > 0) return !ack;
    return req && !ack;
  endfunction

  function automatic bit m_loaduse();
    return ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
  function automatic logic [5:0] m_ctrl();
    if (m_frozen()) return 6'b110101;
    if (m_loaduse()) return 6'b110010;
    if (branch) return 6'b001000;
    return 6'b000000;
  endfunction

  task automatic check_all(input string tag);
    logic [5:0] obs, exp;
    logic [3*CNT_W-1:0] cobs, cexp;
    obs = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
    exp = m_ctrl();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
    end
    checks++;
    assert (err === m_err) else begin
      failures++;
      $error("FAIL %s err observed=%b expected=%b", tag, err, m_err);
    end
    cobs = {lu_cnt, mw_cnt, fl_cnt};
    cexp = PERF ? {CNT_W'(m_lu), CNT_W'(m_mw), CNT_W'(m_fl)} : '0;
    checks++;
    assert (cobs === cexp) else begin
      failures++;
      $error("FAIL %s counters observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
             lu_cnt, mw_cnt, fl_cnt, cexp[3*CNT_W-1 -: CNT_W], cexp[2*CNT_W-1 -: CNT_W],
             cexp[CNT_W-1:0]);
    end
  endtask

  // inputs are already driven; check mid-cycle, then advance one clock and update the model
  task automatic cycle(input string tag);
    bit fr, lu;
    #1;
    check_all(tag);
    fr = m_frozen();
    lu = m_loaduse();
    @(posedge clk);
    if (fr) m_mw++;
    else if (lu) m_lu++;
    else if (branch) m_fl++;
    if (!m_err) begin
      if (fr) begin
        m_unacked++;
        if (m_unacked > MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_unacked = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_rt = 5'd0; ex_memread = 1'b0;
    branch = 1'b0; req = 1'b0; ack = 1'b0;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    m_unacked = 0; m_err = 1'b0; m_lu = 0; m_mw = 0; m_fl = 0;
    #2;
    checks++;
    assert ({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, err} === 7'b0)
    else begin
      failures++;
      $error("FAIL %s reset_outputs observed=%b expected=0", tag,
             {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    req = 1'b1; branch = 1'b1;
    apply_reset("por");
    idle_inputs();
    cycle("idle");

    // load-use on rs, and the same with ex_rt = 0
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    cycle("lu_rs");
    ex_rt = 5'd0; id_rs = 5'd0;
    cycle("lu_zero");

    // rt source gating
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    cycle("rt_unused");
    id_uses_rt = 1'b1;
    cycle("rt_used");

    // branch alone, then branch with load-use
    idle_inputs(); branch = 1'b1;
    cycle("branch");
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    cycle("branch_lu");
    idle_inputs();
    cycle("after_branch");

    // memory wait, ack on 4th cycle, with a pending branch held in ID
    req = 1'b1; branch = 1'b1;
    for (int i = 0; i < 3; i++) cycle("memwait");
    ack = 1'b1;
    cycle("mem_ack");
    ack = 1'b0; req = 1'b0; branch = 1'b0;
    cycle("post_ack");

    // zero-wait access
    req = 1'b1; ack = 1'b1;
    cycle("zero_wait");
    idle_inputs();
    cycle("post_zero");

    // reset in the middle of MEMWAIT; req low afterwards must not freeze
    req = 1'b1;
    cycle("mid_wait1");
    cycle("mid_wait2");
    apply_reset("mid_wait_rst");
    idle_inputs();
    cycle("after_mid_rst");

    // timeout into ERR, then a late ack that must be ignored
    req = 1'b1;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) cycle("to_wait");
    checks++;
    assert (err === 1'b1) else begin
      failures++;
      $error("FAIL timeout_err observed=%b expected=1", err);
    end
    req = 1'b0; ack = 1'b1;
    for (int i = 0; i < 3; i++) cycle("err_late_ack");
    apply_reset("err_rst");
    idle_inputs();
    cycle("after_err_rst");
    checks++;
    assert (err === 1'b0) else begin
      failures++;
      $error("FAIL err_cleared observed=%b expected=0", err);
    end

    // counters: 2 bubbles, 3 freeze cycles, 1 flush from a clean reset
    apply_reset("cnt_rst");
    idle_inputs();
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    cycle("cnt_lu1");
    cycle("cnt_lu2");
    idle_inputs(); req = 1'b1;
    for (int i = 0; i < 3; i++) cycle("cnt_mw");
    ack = 1'b1;
    cycle("cnt_ack");
    idle_inputs(); branch = 1'b1;
    cycle("cnt_fl");
    idle_inputs();
    cycle("cnt_final");

    // random traffic with small register numbers so hazards are frequent
    apply_reset("rand_rst");
    for (int i = 0; i < 400; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      ex_memread = 1'($urandom);
      branch = ($urandom_range(0, 3) == 0);
      req = ($urandom_range(0, 3) == 0) || (m_unacked > 0 && 1'($urandom));
      ack = 1'($urandom);
      if (i == 200) begin
        req = 1'b1; ack = 1'b0;
        for (int k = 0; k < MEM_TIMEOUT + 3; k++) cycle("rand_timeout");
        apply_reset("rand_mid_rst");
      end
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the stall and flush inputs of the IF/ID and ID/EX pipe registers, the EX/MEM pipe register and the PC.
- Detects load-use hazards and taken branches resolved in ID.
- Freezes the pipeline during multi-cycle data-memory accesses through a req/ack FSM with a timeout.
- Pipe registers give stall priority over flush, so this block never asserts stall and flush to the same register in the same cycle.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive MEMWAIT cycles without ack before the error state; legal range 1..255.
- CNT_W, 32: width of the performance counters; used only with HAZARD_PERF_CNT_EN.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_rs_i  in  5  rs field of the instruction in ID.
- id_rt_i  in  5  rt field of the instruction in ID.
- id_uses_rt_i  in  1  the ID instruction reads rt as a source.
- ex_rt_i  in  5  destination rt of the instruction in EX.
- ex_memread_i  in  1  the EX instruction is a load (MemToReg).
- branch_taken_i  in  1  a branch in ID resolved as taken.
- dmem_req_i  in  1  the MEM stage is issuing a data-memory access.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_stall_o  out  1  hold the PC.
- ifid_stall_o  out  1  hold IF/ID.
- ifid_flush_o  out  1  zero IF/ID.
- idex_stall_o  out  1  hold ID/EX.
- idex_flush_o  out  1  insert a bubble into ID/EX.
- exmem_stall_o  out  1  hold EX/MEM.
- err_o  out  1  sticky memory-timeout error.
- loaduse_cnt_o  out  CNT_W  number of load-use bubbles.
- memwait_cnt_o  out  CNT_W  number of frozen cycles.
- flush_cnt_o  out  CNT_W  number of branch flushes.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, timeout counter=0, err_o=0, all counters=0.
  - All stall/flush outputs are 0 while reset is held.
- FSM states: IDLE, MEMWAIT, ERR. The state and timeout counter are registered; stall/flush outputs are combinational from the state and current inputs, so they take effect in the same cycle.
- freeze = (IDLE & dmem_req_i & ~dmem_ack_i) | (MEMWAIT & ~dmem_ack_i) | ERR.
- loaduse = ex_memread_i & (ex_rt_i!=0) & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- Output priority is freeze > loaduse > branch:
  - freeze: pc_stall, ifid_stall, idex_stall and exmem_stall = 1; both flushes = 0.
  - else loaduse: pc_stall=1, ifid_stall=1, idex_flush=1, idex_stall=0, exmem_stall=0, ifid_flush=0. branch_taken_i is ignored because the branch re-evaluates after the bubble.
  - else branch_taken_i: ifid_flush=1; all stalls = 0.
  - else all outputs = 0.
- Transitions:
  - IDLE -> MEMWAIT when dmem_req_i & ~dmem_ack_i; timeout counter <= 1.
  - IDLE stays IDLE when req and ack arrive in the same cycle (zero-wait access, no freeze).
  - MEMWAIT -> IDLE on dmem_ack_i. The pipeline advances in the ack cycle; the timeout counter clears.
  - MEMWAIT, no ack: the counter increments. When the counter == MEM_TIMEOUT with no ack, go to ERR.
  - ERR: err_o=1, permanent freeze. Only rst_i exits ERR; dmem_ack_i is ignored.
- Load-use lasts exactly one cycle without FSM involvement: the load moves to MEM and the compare clears naturally.
- A load-use hazard or taken branch present during a freeze is re-evaluated on the first unfrozen cycle, because the pipe contents are held.
- Reset asserted mid-MEMWAIT returns to IDLE immediately; no pending state survives.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - loaduse_cnt_o increments on each cycle the loaduse bubble is applied.
  - memwait_cnt_o increments on each freeze cycle, including ERR.
  - flush_cnt_o increments on each cycle ifid_flush_o=1.
  - All counters saturate at all-ones and clear on reset.
- Undefined: the three counter ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1, idex_stall=0 that cycle; with the same stimulus and ex_rt_i=0 -> all outputs 0.
- rt source gating: ex_rt_i=9, id_rt_i=9, id_rs_i=3, id_uses_rt_i=0 -> no stall; with id_uses_rt_i=1 -> bubble.
- Branch vs load-use: branch_taken_i=1 alone -> ifid_flush=1 for 1 cycle; branch_taken_i with loaduse true -> ifid_flush=0, bubble only.
- Memory wait: dmem_req_i held, ack in the 4th cycle -> all four stalls high for 3 cycles and low in the ack cycle; req and ack in the same cycle -> no stall.
- Timeout: MEM_TIMEOUT=15, dmem_req_i held with no ack -> ERR after 15 MEMWAIT cycles, err_o=1 and freeze persist; a late ack is ignored; rst_i pulse -> IDLE, err_o=0.
- Counters (HAZARD_PERF_CNT_EN): 2 bubbles, 3 freeze cycles, 1 flush -> loaduse=2, memwait=3, flush=1; without the macro all counters read 0.
